alu_arbiter: RTL

- Shares one combinational 32-bit ALU between two requesters: port 0 is the core execute path and port 1 is the coprocessor/CSR helper.
- Each port uses a valid/ready request channel and a valid/ready response channel backed by a one-entry registered response buffer.
- Arbitration is round-robin. Fixed latency is one cycle from grant to response valid.
- The ALU sits outside this block; the arbiter drives its operand and select inputs and samples its result.

---
 rtl/alu_arbiter.sv | 68 ++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one external ALU between two valid/ready requesters (req0/req1 in, resp0/resp1 out via one-entry buffers, alu_* to the ALU)
module alu_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DWIDTH-1:0]    req0_rs1,
  input  logic [DWIDTH-1:0]    req0_rs2,
  input  logic [SEL_WIDTH-1:0] req0_sel,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic [DWIDTH-1:0]    resp0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DWIDTH-1:0]    req1_rs1,
  input  logic [DWIDTH-1:0]    req1_rs2,
  input  logic [SEL_WIDTH-1:0] req1_sel,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [DWIDTH-1:0]    resp1_data,
  output logic [DWIDTH-1:0]    alu_rs1,
  output logic [DWIDTH-1:0]    alu_rs2,
  output logic [SEL_WIDTH-1:0] alu_sel,
  input  logic [DWIDTH-1:0]    alu_out
);
  logic              last_grant_q, last_grant_d;
  logic              resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
  logic [DWIDTH-1:0] resp0_data_q, resp0_data_d, resp1_data_q, resp1_data_d;
  logic              elig0, elig1, grant0, grant1;
  always_comb begin
    elig0         = !rst && req0_valid && (!resp0_valid_q || resp0_ready);
    elig1         = !rst && req1_valid && (!resp1_valid_q || resp1_ready);
    grant0        = elig0 && (!elig1 || last_grant_q);
    grant1        = elig1 && !grant0;
    last_grant_d  = grant0 ? 1'b0 : grant1 ? 1'b1 : last_grant_q;
    resp0_valid_d = grant0 || (resp0_valid_q && !resp0_ready);
    resp1_valid_d = grant1 || (resp1_valid_q && !resp1_ready);
    resp0_data_d  = grant0 ? alu_out : resp0_data_q;
    resp1_data_d  = grant1 ? alu_out : resp1_data_q;
    alu_rs1       = grant0 ? req0_rs1 : grant1 ? req1_rs1 : '0;
    alu_rs2       = grant0 ? req0_rs2 : grant1 ? req1_rs2 : '0;
    alu_sel       = grant0 ? req0_sel : grant1 ? req1_sel : '0;
    req0_ready    = grant0;
    req1_ready    = grant1;
    resp0_valid   = resp0_valid_q;
    resp1_valid   = resp1_valid_q;
    resp0_data    = resp0_data_q;
    resp1_data    = resp1_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= 1'b1;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
    end
  end
endmodule
